// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// sram_burst_ctrl : burst initiator for the banked SRAM wrapper, credit-gated
//                   read FIFO absorbs read-data backpressure.   Rev 1.0
// ============================================================================
module sram_burst_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 15,
  parameter int LEN_WIDTH     = 16,
  parameter int READ_LATENCY  = 2,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_bwe,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_CEB,
  output logic                  sram_WEB,
  output logic [ADDR_WIDTH-1:0] sram_A,
  output logic [DATA_WIDTH-1:0] sram_D,
  output logic [DATA_WIDTH-1:0] sram_BWEB,
  input  logic [DATA_WIDTH-1:0] sram_Q
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH + READ_LATENCY + 1);
  localparam int PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] fifo_mem [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [CNT_W-1:0]      fifo_count_q;
  logic [CNT_W-1:0]      inflight;
  logic                  credit, issue_wr, issue_rd, push, pop, fifo_empty, drained;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_q[i]);
    end
  end

  // Every issued read reserves a FIFO slot, so a returning word always fits.
  assign credit     = (fifo_count_q + inflight) < CNT_W'(RD_FIFO_DEPTH);
  assign issue_wr   = (state_q == WRITE) && wr_valid;
  assign issue_rd   = (state_q == READ) && credit;
  assign push       = vld_q[READ_LATENCY-1];
  assign fifo_empty = (fifo_count_q == '0);
  assign pop        = !fifo_empty && rd_ready;
  assign drained    = (inflight == '0) && fifo_empty;

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q || ((state_q == DRAIN) && drained);
  assign rd_valid  = !fifo_empty;
  assign rd_data   = fifo_mem[rptr_q];

  assign sram_CEB  = !(issue_wr || issue_rd);
  assign sram_WEB  = !issue_wr;
  assign sram_A    = addr_q;
  assign sram_D    = wr_data;
  assign sram_BWEB = issue_wr ? ~wr_bwe : '1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (credit) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      vld_q   <= (vld_q << 1) | READ_LATENCY'(issue_rd);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == PTR_W'(RD_FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PTR_W'(RD_FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wptr_q] <= sram_Q;
  end

endmodule
`default_nettype wire
